// File: rtl/program_loader_pkg.sv
// Shared definitions for the program loader: loader states and the
// byte/word widths used by the loader core, its byte packer and the
// instruction-memory interface.
package program_loader_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam int unsigned WORD_W = 32;

    typedef enum logic [2:0] {
        ST_HDR,
        ST_LOAD,
        ST_CSUM,
        ST_DONE,
        ST_ERR
    } state_e;

endpackage

// File: rtl/program_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// The loader uses the master modport; the environment (stream source and
// instruction memory) uses the slave modport.
interface program_loader_if #(
    parameter int ADDR_W = 10
);

    logic [program_loader_pkg::BYTE_W-1:0] in_data;
    logic                                  in_valid;
    logic                                  in_ready;

    logic                                  imem_we;
    logic [ADDR_W-1:0]                     imem_addr;
    logic [program_loader_pkg::WORD_W-1:0] imem_wdata;

    modport master (
        input  in_data,
        input  in_valid,
        output in_ready,
        output imem_we,
        output imem_addr,
        output imem_wdata
    );

    modport slave (
        output in_data,
        output in_valid,
        input  in_ready,
        input  imem_we,
        input  imem_addr,
        input  imem_wdata
    );

endinterface

// File: rtl/program_loader_byte_packer.sv
// Assembles little-endian 32-bit words from a byte stream. Byte k of a word
// lands in bits [8k+7:8k]. word_valid_o pulses combinationally on the
// transfer carrying byte 3, with word_o already holding that byte, so the
// consumer can register the complete word on the same edge.
module program_loader_byte_packer
    import program_loader_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear_i,
    input  logic              take_i,
    input  logic [BYTE_W-1:0] byte_i,
    output logic [WORD_W-1:0] word_o,
    output logic              word_valid_o
);

    logic [1:0]            byte_cnt_q;
    logic [3*BYTE_W-1:0]   lanes_q;

    // Track the lane position and capture bytes 0..2; byte 3 is used directly.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples pre-edge values regardless of statement order.
        if (reset || clear_i) begin
            byte_cnt_q <= 2'd0;
            lanes_q    <= '0;
        end else if (take_i) begin
            byte_cnt_q <= byte_cnt_q + 2'd1;
            case (byte_cnt_q)
                2'd0:    lanes_q[0*BYTE_W +: BYTE_W] <= byte_i;
                2'd1:    lanes_q[1*BYTE_W +: BYTE_W] <= byte_i;
                2'd2:    lanes_q[2*BYTE_W +: BYTE_W] <= byte_i;
                default: ;
            endcase
        end
    end

    assign word_valid_o = take_i && (byte_cnt_q == 2'd3);
    assign word_o       = {byte_i, lanes_q};

endmodule

// File: rtl/program_loader.sv
// Boot-time program loader. Parses a little-endian image (word count N,
// N data words, checksum), writes the data words to instruction memory and
// releases the core from reset only once the checksum has matched.
module program_loader
    import program_loader_pkg::*;
#(
    parameter int ADDR_W = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             restart,
    program_loader_if.master bus,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    localparam logic [WORD_W-1:0] MAX_WORDS = WORD_W'(1) << ADDR_W;

    state_e              state_q;
    logic [ADDR_W:0]     n_q;
    logic [ADDR_W:0]     word_cnt_q;
    logic [ADDR_W:0]     word_cnt_d;
    logic [WORD_W-1:0]   sum_q;
    logic [WORD_W-1:0]   sum_d;
    logic                in_ready_q;
    logic                imem_we_q;
    logic [ADDR_W-1:0]   imem_addr_q;
    logic [WORD_W-1:0]   imem_wdata_q;
    logic                cpu_hold_q;
    logic                done_q;
    logic                error_q;

    logic                take;
    logic                rearm;
    logic [WORD_W-1:0]   word;
    logic                word_valid;

    assign take  = bus.in_valid && in_ready_q;
    assign rearm = restart && ((state_q == ST_DONE) || (state_q == ST_ERR));

    program_loader_byte_packer u_packer (
        .clk          (clk),
        .reset        (reset),
        .clear_i      (rearm),
        .take_i       (take),
        .byte_i       (bus.in_data),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    assign word_cnt_d = word_cnt_q + {{ADDR_W{1'b0}}, 1'b1};
    assign sum_d      = sum_q + word;

    // Loader FSM with all outputs registered alongside the state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_HDR;
            n_q          <= '0;
            word_cnt_q   <= '0;
            sum_q        <= '0;
            in_ready_q   <= 1'b1;
            imem_we_q    <= 1'b0;
            imem_addr_q  <= '0;
            imem_wdata_q <= '0;
            cpu_hold_q   <= 1'b1;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
        end else begin
            imem_we_q <= 1'b0;
            case (state_q)
                ST_HDR: begin
                    if (word_valid) begin
                        if (word > MAX_WORDS) begin
                            state_q    <= ST_ERR;
                            in_ready_q <= 1'b0;
                            error_q    <= 1'b1;
                        end else begin
                            n_q     <= word[ADDR_W:0];
                            state_q <= (word == '0) ? ST_CSUM : ST_LOAD;
                        end
                    end
                end
                ST_LOAD: begin
                    if (word_valid) begin
                        imem_we_q    <= 1'b1;
                        imem_addr_q  <= word_cnt_q[ADDR_W-1:0];
                        imem_wdata_q <= word;
                        sum_q        <= sum_d;
                        word_cnt_q   <= word_cnt_d;
                        if (word_cnt_d == n_q) begin
                            state_q <= ST_CSUM;
                        end
                    end
                end
                ST_CSUM: begin
                    if (word_valid) begin
                        in_ready_q <= 1'b0;
                        if (word == sum_q) begin
                            state_q    <= ST_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= ST_ERR;
                            error_q <= 1'b1;
                        end
                    end
                end
                ST_DONE, ST_ERR: begin
                    if (rearm) begin
                        state_q    <= ST_HDR;
                        n_q        <= '0;
                        word_cnt_q <= '0;
                        sum_q      <= '0;
                        in_ready_q <= 1'b1;
                        cpu_hold_q <= 1'b1;
                        done_q     <= 1'b0;
                        error_q    <= 1'b0;
                    end
                end
                default: state_q <= ST_HDR;
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.imem_we    = imem_we_q;
    assign bus.imem_addr  = imem_addr_q;
    assign bus.imem_wdata = imem_wdata_q;
    assign cpu_hold       = cpu_hold_q;
    assign done           = done_q;
    assign error          = error_q;

endmodule

// File: tb/tb_program_loader.sv
// Self-checking bench for program_loader: a 1024-word instance (dut_a) and a
// 4-word instance (dut_b). The reference model works on whole images: it
// serialises header/words/checksum to bytes, predicts which byte transfers
// produce a memory write (and with which address/data), and predicts the
// final outcome from the image's arithmetic.
module tb_program_loader;
    import program_loader_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset     = 1'b1;
    logic restart_a = 1'b0;
    logic restart_b = 1'b0;
    logic cpu_hold_a, done_a, error_a;
    logic cpu_hold_b, done_b, error_b;

    program_loader_if #(.ADDR_W(10)) a_if ();
    program_loader_if #(.ADDR_W(2))  b_if ();

    program_loader #(.ADDR_W(10)) dut_a (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart_a),
        .bus      (a_if.master),
        .cpu_hold (cpu_hold_a),
        .done     (done_a),
        .error    (error_a)
    );

    program_loader #(.ADDR_W(2)) dut_b (
        .clk      (clk),
        .reset    (reset),
        .restart  (restart_b),
        .bus      (b_if.master),
        .cpu_hold (cpu_hold_b),
        .done     (done_b),
        .error    (error_b)
    );

    typedef struct {
        logic        in_ready;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic        cpu_hold;
        logic        done;
        logic        error;
    } obs_t;

    int n_checks = 0;
    int n_pass   = 0;
    int n_fail   = 0;

    logic [31:0] img_words[$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic obs_t sample(input int which);
        obs_t o;
        if (which == 0) begin
            o.in_ready = a_if.in_ready;
            o.we       = a_if.imem_we;
            o.addr     = 32'(a_if.imem_addr);
            o.wdata    = a_if.imem_wdata;
            o.cpu_hold = cpu_hold_a;
            o.done     = done_a;
            o.error    = error_a;
        end else begin
            o.in_ready = b_if.in_ready;
            o.we       = b_if.imem_we;
            o.addr     = 32'(b_if.imem_addr);
            o.wdata    = b_if.imem_wdata;
            o.cpu_hold = cpu_hold_b;
            o.done     = done_b;
            o.error    = error_b;
        end
        return o;
    endfunction

    task automatic drive(input int which, input logic v, input logic [7:0] d);
        if (which == 0) begin
            a_if.in_valid = v;
            a_if.in_data  = d;
        end else begin
            b_if.in_valid = v;
            b_if.in_data  = d;
        end
    endtask

    task automatic check_idle_state(input string tag, input int which);
        obs_t o = sample(which);
        check({tag, ".in_ready"}, 32'(o.in_ready), 32'd1);
        check({tag, ".we"},       32'(o.we),       32'd0);
        check({tag, ".cpu_hold"}, 32'(o.cpu_hold), 32'd1);
        check({tag, ".done"},     32'(o.done),     32'd0);
        check({tag, ".error"},    32'(o.error),    32'd0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        @(posedge clk);
        @(negedge clk);
        for (int w = 0; w < 2; w++) begin
            obs_t o = sample(w);
            check_idle_state("reset", w);
            check("reset.addr",  o.addr,  32'd0);
            check("reset.wdata", o.wdata, 32'd0);
        end
        reset = 1'b0;
    endtask

    task automatic pulse_restart(input int which);
        if (which == 0) restart_a = 1'b1; else restart_b = 1'b1;
        @(posedge clk);
        @(negedge clk);
        restart_a = 1'b0;
        restart_b = 1'b0;
    endtask

    // Stream one image built from hdr_n, img_words and csum; check every
    // cycle against the image-level prediction. stop_after >= 0 truncates the
    // stream; restart_at >= 0 pulses restart just before that byte.
    task automatic run_image(input int which, input logic [31:0] hdr_n,
                             input logic [31:0] csum, input int max_gap,
                             input int stop_after, input int restart_at);
        logic [31:0] cap;
        logic [7:0]  bytes[$];
        logic [31:0] s;
        logic        fits;
        logic        ok;
        int          total;
        int          n_data;
        obs_t        o;

        cap  = (which == 0) ? 32'd1024 : 32'd4;
        fits = (hdr_n <= cap);
        s    = '0;
        for (int k = 0; k < img_words.size(); k++) s += img_words[k];
        ok     = fits && (s == csum);
        n_data = fits ? int'(hdr_n) : 0;

        bytes = {};
        for (int k = 0; k < 4; k++) bytes.push_back(hdr_n[8*k +: 8]);
        if (fits) begin
            for (int w = 0; w < n_data; w++)
                for (int k = 0; k < 4; k++) bytes.push_back(img_words[w][8*k +: 8]);
            for (int k = 0; k < 4; k++) bytes.push_back(csum[8*k +: 8]);
        end
        total = bytes.size();
        if (stop_after >= 0 && stop_after < total) total = stop_after;

        for (int i = 0; i < total; i++) begin
            int gaps = int'($urandom_range(max_gap, 0));
            for (int g = 0; g < gaps; g++) begin
                @(posedge clk);
                @(negedge clk);
                o = sample(which);
                check("gap.we", 32'(o.we), 32'd0);
            end
            if (i == restart_at) begin
                pulse_restart(which);
                check_idle_state("ignored_restart", which);
            end
            o = sample(which);
            check("pre.in_ready", 32'(o.in_ready), 32'd1);
            drive(which, 1'b1, bytes[i]);
            @(posedge clk);
            @(negedge clk);
            drive(which, 1'b0, 8'h00);
            o = sample(which);
            if (i >= 4 && i < 4 + 4 * n_data && ((i - 4) % 4) == 3) begin
                check("wr.we",    32'(o.we), 32'd1);
                check("wr.addr",  o.addr,    32'((i - 4) / 4));
                check("wr.wdata", o.wdata,   img_words[(i - 4) / 4]);
            end else begin
                check("byte.we", 32'(o.we), 32'd0);
            end
            if (i == bytes.size() - 1) begin
                check("end.done",     32'(o.done),     32'(ok));
                check("end.error",    32'(o.error),    32'(!ok));
                check("end.cpu_hold", 32'(o.cpu_hold), 32'(!ok));
                check("end.in_ready", 32'(o.in_ready), 32'd0);
            end else begin
                check("mid.done",     32'(o.done),     32'd0);
                check("mid.error",    32'(o.error),    32'd0);
                check("mid.cpu_hold", 32'(o.cpu_hold), 32'd1);
            end
        end
    endtask

    task automatic restart_and_check(input int which);
        pulse_restart(which);
        check_idle_state("restart", which);
    endtask

    task automatic fixed_three();
        img_words = {32'h0000_0013, 32'h1234_5678, 32'hFFFF_FFFF};
    endtask

    initial begin
        logic [31:0] s;
        drive(0, 1'b0, 8'h00);
        drive(1, 1'b0, 8'h00);
        repeat (2) @(negedge clk);
        do_reset();

        // Reference image, back-to-back then with random gaps.
        fixed_three();
        run_image(0, 32'd3, 32'h1234_568A, 0, -1, -1);
        restart_and_check(0);
        run_image(0, 32'd3, 32'h1234_568A, 5, -1, -1);
        restart_and_check(0);

        // Empty images: matching and mismatching checksum.
        img_words = {};
        run_image(0, 32'd0, 32'h0000_0000, 1, -1, -1);
        restart_and_check(0);
        run_image(0, 32'd0, 32'h0000_0001, 1, -1, -1);
        restart_and_check(0);

        // Off-by-one checksum: all writes, then error.
        fixed_three();
        run_image(0, 32'd3, 32'h1234_568B, 0, -1, -1);
        restart_and_check(0);

        // Random images, some with a corrupted checksum.
        for (int r = 0; r < 6; r++) begin
            int n = int'($urandom_range(8, 1));
            img_words = {};
            s = '0;
            for (int k = 0; k < n; k++) begin
                img_words.push_back($urandom);
                s += img_words[k];
            end
            if (r % 3 == 2) s = s ^ (32'd1 << $urandom_range(31, 0));
            run_image(0, 32'(n), s, 3, -1, -1);
            restart_and_check(0);
        end

        // Small instance: header overflow, then a full-capacity image.
        img_words = {};
        run_image(1, 32'd5, 32'h0, 0, -1, -1);
        restart_and_check(1);
        img_words = {$urandom, $urandom, $urandom, 32'hFFFF_FFFF};
        s = img_words[0] + img_words[1] + img_words[2] + img_words[3];
        run_image(1, 32'd4, s, 2, -1, -1);

        // Reset mid-load discards progress; a fresh load starts at address 0.
        fixed_three();
        run_image(0, 32'd3, 32'h1234_568A, 0, 6, -1);
        do_reset();
        run_image(0, 32'd3, 32'h1234_568A, 2, -1, -1);
        restart_and_check(0);

        // restart during LOAD has no effect on the ongoing load.
        img_words = {32'hDEAD_BEEF, 32'h0000_0001, 32'h8000_0000};
        run_image(0, 32'd3, 32'hDEAD_BEEF + 32'h0000_0001 + 32'h8000_0000, 1, -1, 9);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Boot-time block directly upstream of the processor core. It receives a program image as a byte stream (valid/ready), assembles little-endian 32-bit instruction words and writes them into instruction memory.
- It holds the core in reset until the image has loaded and its checksum has verified.
- The core's fetch stage starts at pc=0 only after cpu_hold deasserts.

Parameters:
ADDR_W, 10, instruction-memory word-address width; capacity MAX_WORDS = 2**ADDR_W
BYTE_W, 8, input byte width (fixed; not overridable in practice)

Ports:
clk  input  1  system clock, all logic on rising edge
reset  input  1  synchronous, active-high reset
in_data  input  8  stream byte
in_valid  input  1  in_data is valid this cycle
in_ready  output  1  loader accepts a byte this cycle (transfer = in_valid & in_ready)
restart  input  1  one-cycle pulse; from DONE/ERR, re-arm for a new image
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_W  word address of the write
imem_wdata  output  32  word to write
cpu_hold  output  1  high = core held in reset
done  output  1  image loaded and checksum matched
error  output  1  load aborted (length overflow or checksum mismatch)

Behaviour:
- Reset values: state=HDR, byte_cnt=0, word_cnt=0, sum=0, in_ready=1, imem_we=0, imem_addr=0, imem_wdata=0, cpu_hold=1, done=0, error=0. Reset mid-load discards all progress. Already-written memory is not cleared.
- Image format, little-endian throughout: 4 bytes word count N, then N×4 data bytes, then 4 bytes checksum C = sum of the N data words mod 2^32.
- Byte assembly: a 2-bit byte_cnt selects the lane. Byte k lands at bits [8k+7:8k]. A word is complete on the transfer with byte_cnt=3. byte_cnt wraps to 0.
- FSM:
  - HDR: assemble N. On completion:
    - N > MAX_WORDS -> ERR.
    - N == 0 -> CSUM.
    - otherwise -> LOAD.
    - N is latched in both non-ERR cases.
  - LOAD: on each completed word:
    - registered write, pulsed the cycle after the final byte: imem_we=1, imem_addr=word_cnt, imem_wdata=word.
    - sum += word (32-bit wrap).
    - word_cnt++.
    - when word_cnt reaches N -> CSUM.
    - Write latency: exactly one cycle after the 4th byte transfer.
  - CSUM: assemble C. On completion: C == sum -> DONE, else -> ERR. Comparison uses the fully updated sum, including a final word completed in the preceding cycle.
  - DONE: in_ready=0, done=1, cpu_hold=0.
  - ERR: in_ready=0, error=1, cpu_hold=1.
- in_ready=1 in HDR/LOAD/CSUM with no backpressure. One byte per cycle is sustained, and gaps (in_valid=0) are allowed anywhere.
- restart:
  - Honoured only in DONE/ERR. Ignored in HDR/LOAD/CSUM.
  - Returns to HDR with all counters, sum, done and error cleared, and cpu_hold=1 in the cycle after the pulse.
- reset and restart together: reset wins.
- word_cnt is ADDR_W+1 bits so that N = MAX_WORDS is representable. The last write goes to address MAX_WORDS-1, and imem_addr never wraps.
- done and error are mutually exclusive and never both high.
- imem_we is never asserted outside LOAD.

Decomposition:
- Shared package: state enum (HDR, LOAD, CSUM, DONE, ERR) and the 32-bit word-width constant, so the core and memory models reference one definition.
- One natural sub-module: byte_packer (byte_cnt plus 32-bit shift/lane register, word_valid pulse). It is reused by all three assembling states.

Test Plan:
- Load N=3, words 0x00000013, 0x12345678, 0xFFFFFFFF, C=0x1234568A, back-to-back bytes -> three imem_we pulses at addr 0,1,2 with the exact words. done=1 and cpu_hold=0 the cycle after the last checksum byte.
- Same image with in_valid deasserted randomly for 0–5 cycles between bytes -> identical writes and final state. No write occurs on an idle cycle.
- N=0, C=0x00000000 -> no imem_we, done=1. N=0, C=0x00000001 -> error=1, cpu_hold stays 1.
- N=3 with C=0x1234568B (off by one) -> all three writes occur, then error=1, done=0, in_ready=0.
- ADDR_W=2: N=5 -> ERR right after the header with no writes. N=4 -> writes at addr 0..3, no wrap, DONE on the correct checksum.
- Pulse reset mid-LOAD after 6 bytes, then restart the image -> writes begin again at addr 0, sum starts at 0, and the correct checksum gives DONE. A restart pulse during LOAD is ignored. A restart pulse in ERR returns to HDR with error=0.
